// File: rtl/fu_wb_if.sv
// Writeback bundle between the functional units and the writeback arbiter.
// The FU side (master) drives done/rd/data. It sees back-pressure through fu_full
// and observes the register-file write and retire reports.
interface fu_wb_if #(
    parameter int N_FU   = 5,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic [N_FU-1:0]        fu_done;
    logic [N_FU*RD_W-1:0]   fu_rd;
    logic [N_FU*DATA_W-1:0] fu_data;
    logic [N_FU-1:0]        fu_full;
    logic                   rf_we;
    logic [RD_W-1:0]        rf_wa;
    logic [DATA_W-1:0]      rf_wd;
    logic                   wb_valid;
    logic [N_FU-1:0]        wb_fu;
    logic                   err_overflow;

    modport master (
        output fu_done, fu_rd, fu_data,
        input  fu_full, rf_we, rf_wa, rf_wd, wb_valid, wb_fu, err_overflow
    );

    modport slave (
        input  fu_done, fu_rd, fu_data,
        output fu_full, rf_we, rf_wa, rf_wd, wb_valid, wb_fu, err_overflow
    );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: one holding entry per functional unit (0 ALU, 1 MEM, 2 MUL,
// 3 DIV, 4 JUMP). The single register-file write port is shared round-robin.
// Each retirement is reported so the scoreboard can release the FU.
module fu_wb_arbiter #(
    parameter int N_FU   = 5,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input logic     clk,
    input logic     rst,
    fu_wb_if.slave  bus
);
    localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]   pend;
    logic [RD_W-1:0]   ent_rd   [N_FU];
    logic [DATA_W-1:0] ent_data [N_FU];
    logic [PTR_W-1:0]  ptr;
    logic              err_q;

    logic [N_FU-1:0]   grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_vld;
    logic [N_FU-1:0]   full;

    logic              vld_p1;
    logic              rf_we_p1;
    logic [RD_W-1:0]   rf_wa_p1;
    logic [DATA_W-1:0] rf_wd_p1;
    logic [N_FU-1:0]   wb_fu_p1;

    // Round-robin pick: scan from the FU after the last winner, wrapping once.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 1; k <= N_FU; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N_FU;
            if (!grant_vld && pend[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

    // A granted entry frees its slot this cycle, so the FU may refill it on the retiring edge.
    assign full = pend & ~grant;

    // Entry control: occupancy, round-robin pointer and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= '0;
            ptr   <= PTR_W'(N_FU - 1);
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (bus.fu_done[i] && !full[i]) begin
                    pend[i] <= 1'b1;
                end else if (grant[i]) begin
                    pend[i] <= 1'b0;
                end
                if (bus.fu_done[i] && full[i]) begin
                    err_q <= 1'b1;
                end
            end
            if (grant_vld) begin
                ptr <= grant_idx;
            end
        end
    end

    // Entry payload: captured only when the slot accepts the pulse; a dropped pulse leaves it intact.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (bus.fu_done[i] && !full[i]) begin
                ent_rd[i]   <= bus.fu_rd[i*RD_W +: RD_W];
                ent_data[i] <= bus.fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Retire stage: register the winner; x0 destinations retire without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            rf_we_p1 <= 1'b0;
            wb_fu_p1 <= '0;
            rf_wa_p1 <= '0;
            rf_wd_p1 <= '0;
        end else begin
            vld_p1   <= grant_vld;
            wb_fu_p1 <= grant;
            rf_we_p1 <= grant_vld && (ent_rd[grant_idx] != '0);
            if (grant_vld) begin
                rf_wa_p1 <= ent_rd[grant_idx];
                rf_wd_p1 <= ent_data[grant_idx];
            end
        end
    end

    assign bus.fu_full      = full;
    assign bus.rf_we        = rf_we_p1;
    assign bus.rf_wa        = rf_wa_p1;
    assign bus.rf_wd        = rf_wd_p1;
    assign bus.wb_valid     = vld_p1;
    assign bus.wb_fu        = wb_fu_p1;
    assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: hand-derived vector table, directed corner sequences,
// and random traffic against a queue-free, rule-level reference model.
module tb_fu_wb_arbiter;
    localparam int N_FU   = 5;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fu_wb_if #(.N_FU(N_FU), .DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    fu_wb_arbiter #(.N_FU(N_FU), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: pending flags, held payloads, last winner, expected outputs.
    bit                m_pend [N_FU];
    logic [RD_W-1:0]   m_rd   [N_FU];
    logic [DATA_W-1:0] m_data [N_FU];
    int                m_last;
    bit                e_valid, e_we, e_err;
    logic [N_FU-1:0]   e_fu;
    logic [RD_W-1:0]   e_wa;
    logic [DATA_W-1:0] e_wd;

    function automatic int m_pick();
        for (int k = 1; k <= N_FU; k++) begin
            if (m_pend[(m_last + k) % N_FU]) return (m_last + k) % N_FU;
        end
        return -1;
    endfunction

    function automatic logic [N_FU-1:0] m_full();
        logic [N_FU-1:0] f;
        int g;
        g = m_pick();
        for (int i = 0; i < N_FU; i++) f[i] = m_pend[i] && (i != g);
        return f;
    endfunction

    function automatic logic [N_FU*DATA_W-1:0] mkdata(input logic [31:0] seed);
        logic [N_FU*DATA_W-1:0] d;
        for (int i = 0; i < N_FU; i++) d[i*DATA_W +: DATA_W] = seed + 32'(i);
        return d;
    endfunction

    // One clock: drive inputs, check fu_full, advance the model, check the registered outputs.
    task automatic cycle(input logic [N_FU-1:0] done, input logic [N_FU*RD_W-1:0] rdv,
                         input logic [N_FU*DATA_W-1:0] dv);
        int g;
        logic [N_FU-1:0] f;
        bus.fu_done = done;
        bus.fu_rd   = rdv;
        bus.fu_data = dv;
        g = m_pick();
        f = m_full();
        chk("fu_full", bus.fu_full, f);
        if (g >= 0) begin
            e_valid = 1'b1;
            e_fu    = N_FU'(1) << g;
            e_we    = (m_rd[g] != 0);
            e_wa    = m_rd[g];
            e_wd    = m_data[g];
            m_last  = g;
            m_pend[g] = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_fu    = '0;
            e_we    = 1'b0;
        end
        for (int i = 0; i < N_FU; i++) begin
            if (done[i]) begin
                if (f[i]) e_err = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_rd[i]   = rdv[i*RD_W +: RD_W];
                    m_data[i] = dv[i*DATA_W +: DATA_W];
                end
            end
        end
        @(posedge clk);
        #1;
        chk("wb_valid", bus.wb_valid, e_valid);
        chk("wb_fu", bus.wb_fu, e_fu);
        chk("rf_we", bus.rf_we, e_we);
        chk("rf_wa", bus.rf_wa, e_wa);
        chk("rf_wd", bus.rf_wd, e_wd);
        chk("err_overflow", bus.err_overflow, e_err);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0, '0, '0);
    endtask

    // One reset edge, optionally with done pulses that must be ignored.
    task automatic do_reset(input logic [N_FU-1:0] done_during);
        rst         = 1'b1;
        bus.fu_done = done_during;
        bus.fu_rd   = {$urandom, $urandom};
        bus.fu_data = mkdata($urandom);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.fu_done = '0;
        for (int i = 0; i < N_FU; i++) m_pend[i] = 1'b0;
        m_last = N_FU - 1;
        e_valid = 0; e_we = 0; e_err = 0; e_fu = '0; e_wa = '0; e_wd = '0;
        chk("rst.wb_valid", bus.wb_valid, 0);
        chk("rst.wb_fu", bus.wb_fu, 0);
        chk("rst.rf_we", bus.rf_we, 0);
        chk("rst.rf_wa", bus.rf_wa, 0);
        chk("rst.rf_wd", bus.rf_wd, 0);
        chk("rst.err_overflow", bus.err_overflow, 0);
        chk("rst.fu_full", bus.fu_full, 0);
    endtask

    typedef struct {
        logic [N_FU-1:0]      done;
        logic [N_FU*RD_W-1:0] rdv;
        logic [31:0]          seed;
        logic [N_FU-1:0]      full;
        bit                   valid;
        logic [N_FU-1:0]      fu;
        bit                   we;
        logic [RD_W-1:0]      wa;
        logic [DATA_W-1:0]    wd;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [N_FU*RD_W-1:0] rdb;
        logic [N_FU*RD_W-1:0] rdv;
        logic [N_FU*DATA_W-1:0] dv;
        logic [N_FU-1:0] done;
        int mul_pos, nret, bubbles, mem_ret;
        logic [DATA_W-1:0] mem_wd;

        rdb = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        //          done      rd            seed          full      v  fu        we wa    wd
        tbl[0]  = '{5'b10000, {5'd1, 20'd0}, 32'h100,      5'b00000, 0, 5'b00000, 0, 5'd0, 32'h0};
        tbl[1]  = '{5'b00000, '0,            32'h0,        5'b00000, 1, 5'b10000, 1, 5'd1, 32'h104};
        tbl[2]  = '{5'b11111, rdb,           32'h1000,     5'b11110, 0, 5'b00000, 0, 5'd1, 32'h104};
        tbl[3]  = '{5'b00000, '0,            32'h0,        5'b11100, 1, 5'b00001, 1, 5'd1, 32'h1000};
        tbl[4]  = '{5'b00000, '0,            32'h0,        5'b11000, 1, 5'b00010, 1, 5'd2, 32'h1001};
        tbl[5]  = '{5'b00000, '0,            32'h0,        5'b10000, 1, 5'b00100, 1, 5'd3, 32'h1002};
        tbl[6]  = '{5'b00000, '0,            32'h0,        5'b00000, 1, 5'b01000, 1, 5'd4, 32'h1003};
        tbl[7]  = '{5'b00000, '0,            32'h0,        5'b00000, 1, 5'b10000, 1, 5'd5, 32'h1004};
        tbl[8]  = '{5'b11111, rdb,           32'h2000,     5'b11110, 0, 5'b00000, 0, 5'd5, 32'h1004};
        tbl[9]  = '{5'b00000, '0,            32'h0,        5'b11100, 1, 5'b00001, 1, 5'd1, 32'h2000};
        tbl[10] = '{5'b00000, '0,            32'h0,        5'b11000, 1, 5'b00010, 1, 5'd2, 32'h2001};
        tbl[11] = '{5'b00000, '0,            32'h0,        5'b10000, 1, 5'b00100, 1, 5'd3, 32'h2002};
        tbl[12] = '{5'b00000, '0,            32'h0,        5'b00000, 1, 5'b01000, 1, 5'd4, 32'h2003};
        tbl[13] = '{5'b00000, '0,            32'h0,        5'b00000, 1, 5'b10000, 1, 5'd5, 32'h2004};
        tbl[14] = '{5'b00001, '0,            32'hDEADBEEF, 5'b00000, 0, 5'b00000, 0, 5'd5, 32'h2004};
        tbl[15] = '{5'b00000, '0,            32'h0,        5'b00000, 1, 5'b00001, 0, 5'd0, 32'hDEADBEEF};
        tbl[16] = '{5'b00000, '0,            32'h0,        5'b00000, 0, 5'b00000, 0, 5'd0, 32'hDEADBEEF};

        rst = 1'b1;
        bus.fu_done = '0;
        bus.fu_rd   = '0;
        bus.fu_data = '0;
        repeat (2) @(posedge clk);
        do_reset('0);

        // Vector table: single JUMP result, two simultaneous bursts, x0 write.
        for (int r = 0; r < 17; r++) begin
            cycle(tbl[r].done, tbl[r].rdv, mkdata(tbl[r].seed));
            chk($sformatf("tbl[%0d].fu_full", r), bus.fu_full, tbl[r].full);
            chk($sformatf("tbl[%0d].wb_valid", r), bus.wb_valid, tbl[r].valid);
            chk($sformatf("tbl[%0d].wb_fu", r), bus.wb_fu, tbl[r].fu);
            chk($sformatf("tbl[%0d].rf_we", r), bus.rf_we, tbl[r].we);
            chk($sformatf("tbl[%0d].rf_wa", r), bus.rf_wa, tbl[r].wa);
            chk($sformatf("tbl[%0d].rf_wd", r), bus.rf_wd, tbl[r].wd);
        end

        // Fairness: ALU refills whenever its slot frees while MUL waits.
        do_reset('0);
        rdv = '0;
        rdv[0*RD_W +: RD_W] = 5'd7;
        rdv[2*RD_W +: RD_W] = 5'd9;
        cycle(5'b00101, rdv, mkdata(32'h3000));
        mul_pos = 0; nret = 0; bubbles = 0;
        for (int c = 0; c < 6; c++) begin
            done = m_full()[0] ? 5'b00000 : 5'b00001;
            cycle(done, rdv, mkdata(32'h3100 + 32'(c) * 32'h10));
            if (bus.wb_valid) nret++;
            else bubbles++;
            if (bus.wb_fu == 5'b00100 && mul_pos == 0) mul_pos = nret;
        end
        chk("fair.mul_retired_by_grant2", (mul_pos >= 1 && mul_pos <= 2), 1);
        chk("fair.no_bubbles", bubbles, 0);
        idle(3);

        // Overflow: MEM pulses again while its entry waits behind ALU.
        do_reset('0);
        rdv = {5'd0, 5'd0, 5'd3, 5'd2, 5'd1};
        cycle(5'b00111, rdv, mkdata(32'hAAAA0000));
        chk("ovf.mem_full", bus.fu_full[1], 1);
        dv = '0;
        dv[1*DATA_W +: DATA_W] = 32'hBBBBBBBB;
        cycle(5'b00010, {5'd0, 5'd0, 5'd0, 5'd17, 5'd0}, dv);
        mem_ret = 0; mem_wd = '0;
        for (int c = 0; c < 5; c++) begin
            if (bus.wb_fu == 5'b00010) begin mem_ret++; mem_wd = bus.rf_wd; end
            cycle('0, '0, '0);
        end
        chk("ovf.mem_retire_count", mem_ret, 1);
        chk("ovf.mem_first_data", mem_wd, 32'hAAAA0001);
        chk("ovf.err_sticky", bus.err_overflow, 1);

        // Reset mid-flight: three entries pending, done pulses on the reset edge ignored.
        cycle(5'b11100, rdb, mkdata(32'h4000));
        do_reset(5'b11111);
        for (int c = 0; c < 3; c++) begin
            cycle('0, '0, '0);
            chk("midrst.no_valid", bus.wb_valid, 0);
        end
        cycle(5'b11111, rdb, mkdata(32'h5000));
        cycle('0, '0, '0);
        chk("midrst.first_is_fu0", bus.wb_fu, 5'b00001);
        idle(5);

        // Random traffic, mostly respecting fu_full with occasional overflows.
        for (int c = 0; c < 400; c++) begin
            done = N_FU'($urandom);
            if ($urandom_range(0, 7) != 0) done = done & ~m_full();
            for (int i = 0; i < N_FU; i++)
                rdv[i*RD_W +: RD_W] = ($urandom_range(0, 3) == 0) ? 5'd0 : RD_W'($urandom_range(1, 31));
            for (int i = 0; i < N_FU; i++) dv[i*DATA_W +: DATA_W] = $urandom;
            cycle(done, rdv, dv);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Writeback stage directly downstream of the functional units: ALU, MEM, MUL, DIV, and the jump FU.
  - The jump FU contributes its return address PC+4 as its result.
- Each FU pulses a done signal with its result and destination register. The block buffers one result per FU and arbitrates the single register-file write port round-robin.
- It reports which FU retired each cycle so the scoreboard/CtrlUnit can release that FU and clear its register status.

Parameters:
- N_FU, 5, number of FU ports. Index 0 ALU, 1 MEM, 2 MUL, 3 DIV, 4 JUMP.
- DATA_W, 32, result width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- fu_done  in  N_FU  per-FU one-cycle result pulse.
- fu_rd  in  N_FU*RD_W  per-FU destination register. FU i occupies bits [i*RD_W +: RD_W].
- fu_data  in  N_FU*DATA_W  per-FU result. FU i occupies bits [i*DATA_W +: DATA_W]. For JUMP this is PC_wb.
- fu_full  out  N_FU  holding entry i is occupied and not granted this cycle; FU i must not pulse done.
- rf_we  out  1  register-file write enable, registered.
- rf_wa  out  RD_W  write address, registered.
- rf_wd  out  DATA_W  write data, registered.
- wb_valid  out  1  one result retired this cycle, registered.
- wb_fu  out  N_FU  one-hot retired FU, registered. All zero when wb_valid=0.
- err_overflow  out  1  sticky flag: a done pulse arrived while fu_full was high.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Per FU, one holding entry: pend[i], rd[i], data[i].
- Latch: at a posedge with fu_done[i]=1 and fu_full[i]=0, load rd/data and set pend[i]=1.
- Grant: combinational, among pend[] only. Search starts at (ptr+1) mod N_FU and wraps; the first pending index wins.
  - Same-edge done pulses are not eligible until the following cycle.
- Retire: on the posedge after a cycle with a grant g:
  - wb_valid=1, wb_fu=onehot(g), rf_wa=rd[g], rf_wd=data[g].
  - rf_we=1 only if rd[g]!=0. x0 results retire with rf_we=0, but still take the slot and still assert wb_valid/wb_fu.
  - pend[g] clears and ptr<=g.
- No grant in a cycle: the next edge drives wb_valid=0, rf_we=0, wb_fu=0. rf_wa/rf_wd hold their previous values.
- Latency: done sampled at edge E, so pend is visible after E. With no contention, rf_we/wb_valid are high for the cycle following edge E+1 (2 edges).
- Throughput: one retirement per cycle. A saturated FU set is served round-robin, and each pending entry waits at most N_FU-1 grants.
- fu_full[i] = pend[i] & ~grant[i].
  - A granted entry may be refilled on the same edge it retires: new data latches and pend stays 1.
- Overflow: done while fu_full[i]=1 drops the new result, keeps the old entry unchanged, and sets err_overflow. err_overflow clears only on rst.
- Reset:
  - pend=0, ptr=N_FU-1 (FU0 has first priority), rf_we=0, wb_valid=0, wb_fu=0, rf_wa=0, rf_wd=0, err_overflow=0.
  - Reset mid-operation discards all pending results, and any done pulse on the reset edge is ignored.
- No combinational path from fu_done/fu_data to any output except none: fu_full depends only on internal state.

Test Plan:
- Single result: after reset, JUMP done with rd=1, data=0x00000104 → two edges later rf_we=1, rf_wa=1, rf_wd=0x104, wb_fu=5'b10000 for exactly one cycle.
- x0 write: ALU done with rd=0, data=0xDEADBEEF → wb_valid=1, wb_fu=5'b00001, rf_we=0.
- Simultaneous arrivals: all five done in one cycle (rd=i+1) → retire order FU0,1,2,3,4 on consecutive cycles. A second burst then starts at FU0 because ptr=4 wraps to 0.
- Fairness: ALU re-pulses done every time its fu_full drops while MUL is pending → MUL retires within 2 grants and is never starved. ALU's refill-on-grant keeps back-to-back retirement with no bubble.
- Overflow: MEM done twice while pending and not granted (hold the port busy with others) → the first data is retired, the second is dropped, and err_overflow=1 sticks until rst.
- Reset mid-flight: three entries pending, rst asserted for 1 cycle → no wb_valid afterwards, fu_full=0, ptr=4, err_overflow=0.
